// File: rtl/sar_adc_control.sv
`timescale 1ns/1ps
// sar_adc_control
// Successive-approximation ADC controller. Drives a trial code onto the R2R
// ladder (via dac_drive), reads the external comparator and binary-searches
// the input voltage down to a WIDTH-bit result.
//
// Optional feature macro: SAR_AVG4_EN
//   defined   -> one start runs 4 back-to-back conversions and reports their
//                truncated mean
//   undefined -> one conversion per start
//
// Ports:
//   clk       system clock (10 MHz nominal)
//   rst_n     asynchronous active-low reset
//   ena       block enable; low aborts any conversion
//   start     conversion request, honoured in IDLE only
//   cmp_in    asynchronous comparator output (1 = Vin above ladder)
//   dac_code  trial code to the ladder; holds the final code after completion
//   result    last completed conversion
//   valid     one-cycle pulse when result updates
//   busy      high while converting
module sar_adc_control #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 16   // legal 3..255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy
);

    localparam int               IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]       CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0]    TOP_IDX    = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY   = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    bit_idx, idx_nxt, idx_dn;
    logic [7:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] dac_nxt, result_nxt, code_dec;
    logic             valid_nxt, busy_nxt;
    logic             cmp_meta, cmp_s;

`ifdef SAR_AVG4_EN
    localparam int AW = WIDTH + 2;
    logic [AW-1:0] acc, acc_nxt, acc_sum;
    logic [1:0]    conv, conv_nxt;
`endif

    // Comparator is asynchronous to clk; SETTLE_CYCLES >= 3 leaves room for
    // the ladder change plus these two flops before the decision edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dac_code <= '0;
            result   <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            bit_idx  <= '0;
            cnt      <= '0;
`ifdef SAR_AVG4_EN
            acc      <= '0;
            conv     <= '0;
`endif
        end else begin
            state    <= state_nxt;
            dac_code <= dac_nxt;
            result   <= result_nxt;
            valid    <= valid_nxt;
            busy     <= busy_nxt;
            bit_idx  <= idx_nxt;
            cnt      <= cnt_nxt;
`ifdef SAR_AVG4_EN
            acc      <= acc_nxt;
            conv     <= conv_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        dac_nxt    = dac_code;
        result_nxt = result;
        valid_nxt  = 1'b0;
        busy_nxt   = busy;
        idx_nxt    = bit_idx;
        cnt_nxt    = cnt;
        idx_dn     = bit_idx - IW'(1);
        // Current code with the bit under test resolved: keep it only when
        // the input is above the ladder.
        code_dec          = dac_code;
        code_dec[bit_idx] = cmp_s;
`ifdef SAR_AVG4_EN
        acc_nxt  = acc;
        conv_nxt = conv;
        acc_sum  = acc + AW'(code_dec);
`endif

        if (!ena) begin
            // Abort: dac_code keeps its partial value, result untouched.
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
`ifdef SAR_AVG4_EN
            acc_nxt   = '0;
            conv_nxt  = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dac_nxt   = MSB_ONLY;
                        idx_nxt   = TOP_IDX;
                        cnt_nxt   = CNT_RELOAD;
                        busy_nxt  = 1'b1;
                        state_nxt = SETTLE;
`ifdef SAR_AVG4_EN
                        acc_nxt   = '0;
                        conv_nxt  = '0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt != 8'd0) begin
                        cnt_nxt = cnt - 8'd1;
                    end else if (bit_idx != '0) begin
                        dac_nxt         = code_dec;
                        dac_nxt[idx_dn] = 1'b1;
                        idx_nxt         = idx_dn;
                        cnt_nxt         = CNT_RELOAD;
                    end else begin
`ifdef SAR_AVG4_EN
                        if (conv == 2'd3) begin
                            dac_nxt    = code_dec;
                            result_nxt = acc_sum[AW-1:2];
                            valid_nxt  = 1'b1;
                            busy_nxt   = 1'b0;
                            state_nxt  = IDLE;
                            acc_nxt    = acc_sum;
                        end else begin
                            // Next conversion restarts on this same edge.
                            acc_nxt  = acc_sum;
                            conv_nxt = conv + 2'd1;
                            dac_nxt  = MSB_ONLY;
                            idx_nxt  = TOP_IDX;
                            cnt_nxt  = CNT_RELOAD;
                        end
`else
                        dac_nxt    = code_dec;
                        result_nxt = code_dec;
                        valid_nxt  = 1'b1;
                        busy_nxt   = 1'b0;
                        state_nxt  = IDLE;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_control.sv
`timescale 1ns/1ps
// Scoreboarded bench for sar_adc_control (default build, SETTLE_CYCLES=4).
// Comparator model: cmp_in = (dac_code <= vin).
module tb_sar_adc_control;

    localparam int W   = 8;
    localparam int S   = 4;
    localparam int LAT = W * S;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         start = 1'b0;
    logic         cmp_in;
    logic [W-1:0] dac_code, result;
    logic         valid, busy;
    logic [7:0]   vin = 8'h00;

    int pass_cnt = 0;
    int total = 0;
    int cyc = 0;
    int e0 = 0;
    logic [7:0] last_exp = 8'h00;

    typedef struct { logic [7:0] res; int cyc; } exp_t;
    exp_t q[$];

    sar_adc_control #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp_in(cmp_in),
        .dac_code(dac_code), .result(result), .valid(valid), .busy(busy)
    );

    assign cmp_in = (dac_code <= vin);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act == exp_v) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    // Binary search as stated: keep each bit whose trial code is <= vin.
    function automatic logic [7:0] ref_conv(input logic [7:0] v);
        logic [7:0] c = 8'h00;
        for (int b = 7; b >= 0; b--)
            if ((c | 8'(1 << b)) <= v) c = c | 8'(1 << b);
        return c;
    endfunction

    // Trial code presented during step j (0 = MSB trial).
    function automatic logic [7:0] trial(input logic [7:0] v, input int j);
        logic [7:0] c = 8'h00;
        for (int b = 7; b > 7 - j; b--)
            if ((c | 8'(1 << b)) <= v) c = c | 8'(1 << b);
        return c | 8'(1 << (7 - j));
    endfunction

    // Returns at the negedge following the start-sampling edge (cyc == e0).
    task automatic pulse_start(input logic [7:0] v, input bit push);
        exp_t e;
        @(negedge clk);
        vin   = v;
        start = 1'b1;
        e0    = cyc + 1;
        if (push) begin
            e.res = ref_conv(v);
            e.cyc = e0 + LAT;
            q.push_back(e);
            last_exp = e.res;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every valid must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            chk("valid_busy_exclusive", int'(busy), 0);
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", int'(result), int'(e.res));
                chk("valid_cycle", cyc, e.cyc);
                chk("dac_code_final", int'(dac_code), int'(e.res));
            end
        end
    end

    initial begin
        int bcnt;
        int guard;
        // Reset state
        #2;
        chk("rst_dac", int'(dac_code), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mid-scale example: busy window and final code
        pulse_start(8'hA5, 1);
        bcnt = 0;
        for (int k = 0; k < LAT; k++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        chk("busy_cycles", bcnt, LAT);
        chk("busy_low_after", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("dac_holds_A5", int'(dac_code), 8'hA5);

        // Boundaries
        pulse_start(8'h00, 1);
        repeat (LAT + 3) @(negedge clk);
        pulse_start(8'hFF, 1);
        repeat (LAT + 3) @(negedge clk);
        pulse_start(8'h80, 1);
        for (int k = 0; k < LAT; k++) begin
            chk("trial_seq_80", int'(dac_code), int'(trial(8'h80, k / S)));
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // start re-pulsed mid-conversion is ignored
        pulse_start(8'h5A, 1);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 10) @(negedge clk);

        // start held high: two conversions, valids LAT+1 apart
        begin
            exp_t e;
            @(negedge clk);
            vin   = 8'h3C;
            start = 1'b1;
            e0    = cyc + 1;
            e.res = ref_conv(8'h3C);
            e.cyc = e0 + LAT;
            q.push_back(e);
            e.cyc = e0 + 2 * LAT + 1;
            q.push_back(e);
            last_exp = e.res;
            while (cyc < e0 + LAT + 1) @(negedge clk);
            start = 1'b0;
            repeat (LAT + 10) @(negedge clk);
        end

        // ena dropped mid-conversion
        pulse_start(8'h33, 0);
        repeat (14) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("ena_abort_busy", int'(busy), 0);
        chk("ena_abort_result", int'(result), int'(last_exp));
        ena = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        chk("ena_abort_result_later", int'(result), int'(last_exp));

        // ena low in IDLE blocks start
        ena = 1'b0;
        pulse_start(8'h44, 0);
        chk("ena_low_blocks_busy", int'(busy), 0);
        ena = 1'b1;
        repeat (LAT + 5) @(negedge clk);

        // Asynchronous reset mid-conversion
        pulse_start(8'h77, 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dac", int'(dac_code), 0);
        chk("arst_result", int'(result), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = 8'h00;
        repeat (2) @(negedge clk);

        // Randomized conversions
        for (int n = 0; n < 20; n++) begin
            pulse_start(8'($urandom_range(0, 255)), 1);
            repeat (LAT + 1 + $urandom_range(0, 5)) @(negedge clk);
        end

        // Drain, bounded
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_empty", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
